// File: rtl/dam_stim_driver.sv
// Command FIFO plus issue/settle/wait/report sequencer driving the DAM engine.
// Golden-value checking is built in only when DAM_STIM_DRIVER_CHECK_EN is defined.
module dam_stim_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_i,
  input  logic [7:0] cmd_j,
  input  logic [7:0] cmd_k,
  input  logic       cmd_op,
  output logic [7:0] i,
  output logic [7:0] j,
  output logic [7:0] k,
  output logic       operation,
  input  logic       in_valid,
  input  logic [7:0] vo,
  input  logic       out_valid,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [7:0] res_expected,
  output logic       res_err,
  output logic       res_timeout,
  output logic       busy,
  output logic [7:0] err_count
);
  // state    | meaning
  // S_IDLE   | operands at 0, waiting for a queued command
  // S_ISSUE  | waiting for in_valid, then pops head onto the pins
  // S_SETTLE | engine output still reflects old operands; golden registered
  // S_WAIT   | waiting for out_valid or timeout
  // S_REPORT | one-cycle result report
  localparam int         AW          = $clog2(DEPTH);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_REPORT} state_t;
  state_t state;

  logic [24:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [24:0] head;
  logic [7:0]  wait_cnt;
  logic        mismatch;
  logic        report_err;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state == S_ISSUE) && in_valid && !fifo_empty;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd_i, cmd_j, cmd_k, cmd_op};
  end

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

`ifdef DAM_STIM_DRIVER_CHECK_EN
  logic [8:0] diff;
  logic [7:0] mag;
  logic [7:0] golden;
  logic [7:0] expected_q;

  always_comb begin
    diff   = {1'b0, i} - {1'b0, j};
    mag    = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];
    golden = operation ? (mag + k) : (mag * k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    expected_q <= '0;
    else if (state == S_SETTLE) expected_q <= golden;
  end

  assign res_expected = expected_q;
  assign mismatch     = (vo != expected_q);
`else
  assign res_expected = 8'd0;
  assign mismatch     = 1'b0;
`endif

  assign report_err = !out_valid || mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      operation   <= 1'b0;
      wait_cnt    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: if (!fifo_empty) state <= S_ISSUE;
        S_ISSUE: begin
          if (pop) begin
            {i, j, k, operation} <= head;
            wait_cnt             <= '0;
            state                <= S_SETTLE;
          end
        end
        S_SETTLE: state <= S_WAIT;
        S_WAIT: begin
          // Timeout fires on the WAIT cycle where the counter equals TIMEOUT.
          if (out_valid || (wait_cnt == TIMEOUT_CNT)) begin
            res_valid            <= 1'b1;
            res_timeout          <= !out_valid;
            res_data             <= out_valid ? vo : 8'd0;
            res_err              <= report_err;
            if (report_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            {i, j, k, operation} <= '0;
            state                <= S_REPORT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
